effect_unit: RTL and testbench

//   Registered successor to the combinational store-effect decoder. Holds the

---
 rtl/effect_unit.sv | 128 ++++++++++++
 tb/tb_effect_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/effect_unit.sv
// Flags register with a LIFO flag save stack and a registered store decision
// derived from the 3-bit instruction effect code evaluated against held flags.
module effect_unit #(
  parameter  int FLAG_WIDTH  = 5,
  parameter  int STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  flags_we,
  input  logic [2:0]            effect,
  input  logic                  eval_valid,
  output logic                  store,
  output logic                  store_valid,
  output logic [FLAG_WIDTH-1:0] flags_out,
  input  logic                  push,
  input  logic                  pop,
  output logic [SP_W-1:0]       stack_level,
  output logic                  stack_overflow,
  output logic                  stack_underflow,
  input  logic                  err_clear
);

  localparam int              IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] ONE   = SP_W'(1);

  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic                  store_q, store_d;
  logic                  vld_q, vld_d;
  logic [SP_W-1:0]       level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [FLAG_WIDTH-1:0] stack_q [2**IDX_W];

  logic            push_only, pop_only, push_ok, pop_ok, ovf_set, unf_set;
  logic [SP_W-1:0] level_m1;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Bit map: [0] overflow, [1] carry, [2] zero, [3] negative.
  function automatic logic effect_hit(input logic [2:0] eff,
                                      input logic [FLAG_WIDTH-1:0] f);
    logic v, z, n;
    v = f[0];
    z = f[2];
    n = f[3];
    case (eff)
      3'd0:    effect_hit = z;
      3'd1:    effect_hit = ~z;
      3'd2:    effect_hit = ~z & ~n;
      3'd3:    effect_hit = 1'b1;
      3'd4:    effect_hit = ~n;
      3'd5:    effect_hit = n;
      3'd6:    effect_hit = ~v;
      default: effect_hit = 1'b0;
    endcase
  endfunction

  always_comb begin
    push_only = push & ~pop;
    pop_only  = pop & ~push;
    push_ok   = push_only & (level_q != FULL);
    pop_ok    = pop_only & (level_q != '0);
    ovf_set   = push_only & (level_q == FULL);
    unf_set   = pop_only & (level_q == '0);
    level_m1  = level_q - ONE;
    wr_idx    = level_q[IDX_W-1:0];
    rd_idx    = level_m1[IDX_W-1:0];
  end

  always_comb begin
    flags_d = flags_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    store_d = 1'b0;
    vld_d   = eval_valid;

    // Evaluation always sees the flags as they stood before this edge.
    if (eval_valid) store_d = effect_hit(effect, flags_q);

    if (pop_ok)        flags_d = stack_q[rd_idx];
    else if (flags_we) flags_d = flags_in;

    if (push_ok)     level_d = level_q + ONE;
    else if (pop_ok) level_d = level_m1;

    // A same-cycle error event takes precedence over the clear.
    if (err_clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
      store_q <= 1'b0;
      vld_q   <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      store_q <= store_d;
      vld_q   <= vld_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is plain RAM: no reset, written only on a legal push.
  always_ff @(posedge clock) begin
    if (push_ok) stack_q[wr_idx] <= flags_q;
  end

  assign store           = store_q;
  assign store_valid     = vld_q;
  assign flags_out       = flags_q;
  assign stack_level     = level_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_effect_unit.sv
// Bench for effect_unit: table-driven effect decoding plus hand-written
// stack, same-cycle and reset sequences, with a store scoreboard queue.
module tb_effect_unit;

  localparam int FW   = 5;
  localparam int D    = 4;
  localparam int SP_W = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic [FW-1:0] flags_in;
  logic          flags_we;
  logic [2:0]    effect;
  logic          eval_valid;
  logic          store;
  logic          store_valid;
  logic [FW-1:0] flags_out;
  logic          push;
  logic          pop;
  logic [SP_W-1:0] stack_level;
  logic          stack_overflow;
  logic          stack_underflow;
  logic          err_clear;

  effect_unit #(.FLAG_WIDTH(FW), .STACK_DEPTH(D)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flags_in       (flags_in),
    .flags_we       (flags_we),
    .effect         (effect),
    .eval_valid     (eval_valid),
    .store          (store),
    .store_valid    (store_valid),
    .flags_out      (flags_out),
    .push           (push),
    .pop            (pop),
    .stack_level    (stack_level),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow),
    .err_clear      (err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [FW-1:0] flags;
    logic [2:0]    eff;
    logic          exp_store;
  } vec_t;

  vec_t vecs [16];
  logic sb [$];
  int   checks   = 0;
  int   failures = 0;
  logic [FW-1:0] vals [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    flags_we   = 1'b0;
    eval_valid = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_clear  = 1'b0;
  endtask

  task automatic eval(input logic [2:0] eff, input logic exp_store);
    eval_valid = 1'b1;
    effect     = eff;
    sb.push_back(exp_store);
  endtask

  // One clock: apply current inputs, then compare the store outputs.
  task automatic tick(input string tag);
    logic e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".store_valid"}, 32'(store_valid), 32'd1);
      check({tag, ".store"}, 32'(store), 32'(e));
    end else begin
      check({tag, ".store_valid_idle"}, 32'(store_valid), 32'd0);
      check({tag, ".store_idle"}, 32'(store), 32'd0);
    end
    idle_inputs();
  endtask

  task automatic load(input logic [FW-1:0] f);
    flags_we = 1'b1;
    flags_in = f;
    tick("load");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'b00100, 3'd0, 1'b1};
    vecs[1]  = '{5'b00100, 3'd1, 1'b0};
    vecs[2]  = '{5'b01000, 3'd2, 1'b0};
    vecs[3]  = '{5'b01000, 3'd3, 1'b1};
    vecs[4]  = '{5'b01000, 3'd4, 1'b0};
    vecs[5]  = '{5'b01000, 3'd5, 1'b1};
    vecs[6]  = '{5'b01000, 3'd6, 1'b1};
    vecs[7]  = '{5'b01000, 3'd7, 1'b0};
    vecs[8]  = '{5'b00000, 3'd0, 1'b0};
    vecs[9]  = '{5'b00000, 3'd1, 1'b1};
    vecs[10] = '{5'b00000, 3'd2, 1'b1};
    vecs[11] = '{5'b00000, 3'd4, 1'b1};
    vecs[12] = '{5'b00001, 3'd6, 1'b0};
    vecs[13] = '{5'b10011, 3'd7, 1'b0};
    vecs[14] = '{5'b01100, 3'd2, 1'b0};
    vecs[15] = '{5'b10010, 3'd5, 1'b0};
    vals[0] = 5'h11;
    vals[1] = 5'h02;
    vals[2] = 5'h13;
    vals[3] = 5'h0C;

    reset_n  = 1'b0;
    flags_in = '0;
    effect   = '0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    check("rst.flags_out", 32'(flags_out), 32'd0);
    check("rst.store_valid", 32'(store_valid), 32'd0);
    check("rst.store", 32'(store), 32'd0);
    check("rst.level", 32'(stack_level), 32'd0);
    check("rst.ovf", 32'(stack_overflow), 32'd0);
    check("rst.unf", 32'(stack_underflow), 32'd0);
    reset_n = 1'b1;

    // Effect decoding table
    for (int i = 0; i < 16; i++) begin
      load(vecs[i].flags);
      check("tbl.flags_out", 32'(flags_out), 32'(vecs[i].flags));
      eval(vecs[i].eff, vecs[i].exp_store);
      tick("tbl");
    end
    tick("tbl.drain");

    // Eval in the same cycle as flags_we sees the old flags
    load(5'b00000);
    flags_we = 1'b1;
    flags_in = 5'b00100;
    eval(3'd0, 1'b0);
    tick("same.old");
    eval(3'd0, 1'b1);
    tick("same.new");
    tick("same.drain");

    // Fill the stack, overflow, then LIFO restore and underflow
    for (int i = 0; i < D; i++) begin
      load(vals[i]);
      push = 1'b1;
      tick("push");
      check("push.level", 32'(stack_level), 32'(i + 1));
    end
    push = 1'b1;
    tick("push5");
    check("ovf.level", 32'(stack_level), 32'd4);
    check("ovf.flag", 32'(stack_overflow), 32'd1);
    check("ovf.flags_out", 32'(flags_out), 32'(vals[3]));
    load(5'h1F);
    for (int i = 0; i < D; i++) begin
      pop = 1'b1;
      tick("pop");
      check("pop.flags_out", 32'(flags_out), 32'(vals[D - 1 - i]));
      check("pop.level", 32'(stack_level), 32'(D - 1 - i));
    end
    pop = 1'b1;
    tick("pop5");
    check("unf.flag", 32'(stack_underflow), 32'd1);
    check("unf.flags_out", 32'(flags_out), 32'(vals[0]));
    check("unf.level", 32'(stack_level), 32'd0);
    check("unf.ovf_sticky", 32'(stack_overflow), 32'd1);
    err_clear = 1'b1;
    tick("clr");
    check("clr.ovf", 32'(stack_overflow), 32'd0);
    check("clr.unf", 32'(stack_underflow), 32'd0);

    // push with flags_we stacks the old value
    push     = 1'b1;
    flags_we = 1'b1;
    flags_in = 5'h0A;
    tick("pushwe");
    check("pushwe.flags_out", 32'(flags_out), 32'h0A);
    check("pushwe.level", 32'(stack_level), 32'd1);
    pop = 1'b1;
    tick("pushwe.pop");
    check("pushwe.restored", 32'(flags_out), 32'(vals[0]));
    check("pushwe.level0", 32'(stack_level), 32'd0);

    // push and pop together: no stack change, no errors
    push = 1'b1;
    tick("pp.pre");
    load(5'h05);
    push = 1'b1;
    pop  = 1'b1;
    tick("pp");
    check("pp.level", 32'(stack_level), 32'd1);
    check("pp.flags_out", 32'(flags_out), 32'h05);
    check("pp.ovf", 32'(stack_overflow), 32'd0);
    check("pp.unf", 32'(stack_underflow), 32'd0);
    push = 1'b1;
    pop  = 1'b1;
    tick("pp0");
    pop = 1'b1;
    tick("pp.pop");
    check("pp.restored", 32'(flags_out), 32'(vals[0]));

    // Simultaneous overflow and err_clear: the set wins
    for (int i = 0; i < D; i++) begin
      push = 1'b1;
      tick("refill");
    end
    check("refill.level", 32'(stack_level), 32'd4);
    push      = 1'b1;
    err_clear = 1'b1;
    tick("ovfclr");
    check("ovfclr.ovf", 32'(stack_overflow), 32'd1);
    err_clear = 1'b1;
    tick("clr2");
    check("clr2.ovf", 32'(stack_overflow), 32'd0);

    // Asynchronous reset in the middle of an evaluation
    eval(3'd3, 1'b1);
    tick("pre_rst");
    eval_valid = 1'b1;
    effect     = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.store_valid", 32'(store_valid), 32'd0);
    check("arst.store", 32'(store), 32'd0);
    check("arst.level", 32'(stack_level), 32'd0);
    check("arst.flags_out", 32'(flags_out), 32'd0);
    @(posedge clock);
    #1;
    check("arst.hold_valid", 32'(store_valid), 32'd0);
    idle_inputs();
    reset_n = 1'b1;
    tick("post_rst");
    check("post.level", 32'(stack_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
